// File: rtl/core_alu_seq_pkg.sv
// Shared opcode, state and ALU control-word definitions for core_alu_seq.
// CORE_ALU_SEQ_ADD16_EN selects whether opcode E decodes to the two-pass add.
package core_alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_LD    = 4'h0,
        OP_ORA   = 4'h1,
        OP_AND   = 4'h2,
        OP_EOR   = 4'h3,
        OP_ADC   = 4'h4,
        OP_SBC   = 4'h5,
        OP_CMP   = 4'h6,
        OP_BIT   = 4'h7,
        OP_ASL   = 4'h8,
        OP_LSR   = 4'h9,
        OP_ROL   = 4'hA,
        OP_ROR   = 4'hB,
        OP_INC   = 4'hC,
        OP_DEC   = 4'hD,
        OP_ADD16 = 4'hE,
        OP_NOP   = 4'hF
    } op_type;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_EXEC_HI
    } state_type;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [3:0] {
        FN_PASS_A,
        FN_PASS_B,
        FN_OR,
        FN_AND,
        FN_EOR,
        FN_ADD,
        FN_SUB,
        FN_BIT,
        FN_ASL,
        FN_LSR,
        FN_ROL,
        FN_ROR,
        FN_INC,
        FN_DEC
    } alu_fn_type;

    typedef enum logic [1:0] {
        CIN_FLAG,
        CIN_ZERO,
        CIN_ONE
    } cin_type;

    typedef struct packed {
        alu_fn_type fn;
        cin_type    cin;
        logic [3:0] upd;
    } alu_ctrl_type;

    localparam logic [3:0] UPD_NONE = 4'b0000;
    localparam logic [3:0] UPD_NZ   = 4'b1010;
    localparam logic [3:0] UPD_NZC  = 4'b1011;
    localparam logic [3:0] UPD_NVZ  = 4'b1110;
    localparam logic [3:0] UPD_ALL  = 4'b1111;

    localparam alu_ctrl_type CTRL_LD    = '{FN_PASS_B, CIN_ZERO, UPD_NZ};
    localparam alu_ctrl_type CTRL_ORA   = '{FN_OR,     CIN_ZERO, UPD_NZ};
    localparam alu_ctrl_type CTRL_AND   = '{FN_AND,    CIN_ZERO, UPD_NZ};
    localparam alu_ctrl_type CTRL_EOR   = '{FN_EOR,    CIN_ZERO, UPD_NZ};
    localparam alu_ctrl_type CTRL_ADC   = '{FN_ADD,    CIN_FLAG, UPD_ALL};
    localparam alu_ctrl_type CTRL_SBC   = '{FN_SUB,    CIN_FLAG, UPD_ALL};
    localparam alu_ctrl_type CTRL_CMP   = '{FN_SUB,    CIN_ONE,  UPD_NZC};
    localparam alu_ctrl_type CTRL_BIT   = '{FN_BIT,    CIN_ZERO, UPD_NVZ};
    localparam alu_ctrl_type CTRL_ASL   = '{FN_ASL,    CIN_ZERO, UPD_NZC};
    localparam alu_ctrl_type CTRL_LSR   = '{FN_LSR,    CIN_ZERO, UPD_NZC};
    localparam alu_ctrl_type CTRL_ROL   = '{FN_ROL,    CIN_FLAG, UPD_NZC};
    localparam alu_ctrl_type CTRL_ROR   = '{FN_ROR,    CIN_FLAG, UPD_NZC};
    localparam alu_ctrl_type CTRL_INC   = '{FN_INC,    CIN_ZERO, UPD_NZ};
    localparam alu_ctrl_type CTRL_DEC   = '{FN_DEC,    CIN_ZERO, UPD_NZ};
    localparam alu_ctrl_type CTRL_ADD16 = '{FN_ADD,    CIN_ZERO, UPD_NONE};
    localparam alu_ctrl_type CTRL_NOP   = '{FN_PASS_A, CIN_ZERO, UPD_NONE};

    function automatic alu_ctrl_type op_ctrl(input op_type op);
        alu_ctrl_type c;
        c = CTRL_NOP;
        unique case (op)
            OP_LD:    c = CTRL_LD;
            OP_ORA:   c = CTRL_ORA;
            OP_AND:   c = CTRL_AND;
            OP_EOR:   c = CTRL_EOR;
            OP_ADC:   c = CTRL_ADC;
            OP_SBC:   c = CTRL_SBC;
            OP_CMP:   c = CTRL_CMP;
            OP_BIT:   c = CTRL_BIT;
            OP_ASL:   c = CTRL_ASL;
            OP_LSR:   c = CTRL_LSR;
            OP_ROL:   c = CTRL_ROL;
            OP_ROR:   c = CTRL_ROR;
            OP_INC:   c = CTRL_INC;
            OP_DEC:   c = CTRL_DEC;
`ifdef CORE_ALU_SEQ_ADD16_EN
            OP_ADD16: c = CTRL_ADD16;
`else
            OP_ADD16: c = CTRL_NOP;
`endif
            OP_NOP:   c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/core_alu_seq_if.sv
// Request/response and flag-write bundle between the core and core_alu_seq.
// master drives requests and flag writes; slave is the sequencer.
interface core_alu_seq_if;
    logic        I_req_valid;
    logic        O_req_ready;
    logic [3:0]  I_req_op;
    logic [15:0] I_req_lhs;
    logic [7:0]  I_req_rhs;
    logic        I_flags_wr;
    logic [3:0]  I_flags;
    logic        O_resp_valid;
    logic [7:0]  O_result;
    logic [7:0]  O_result_hi;
    logic        O_page_cross;
    logic [3:0]  O_flags;

    modport master (
        output I_req_valid, I_req_op, I_req_lhs, I_req_rhs,
        output I_flags_wr, I_flags,
        input  O_req_ready, O_resp_valid, O_result, O_result_hi,
        input  O_page_cross, O_flags
    );

    modport slave (
        input  I_req_valid, I_req_op, I_req_lhs, I_req_rhs,
        input  I_flags_wr, I_flags,
        output O_req_ready, O_resp_valid, O_result, O_result_hi,
        output O_page_cross, O_flags
    );
endinterface

// File: rtl/core_alu.sv
// 8-bit combinational ALU: result plus candidate {N,V,Z,C}.
// The caller decides which candidate flags are committed.
module core_alu
    import core_alu_seq_pkg::*;
(
    input  alu_fn_type fn,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] y,
    output logic [3:0] flags
);

    logic [7:0] bx;
    logic [8:0] sum;
    logic       c;
    logic       v;

    // Shared adder (subtract is add of ~b) and per-function result select
    always_comb begin
        bx  = (fn == FN_SUB) ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {8'd0, cin};
        y   = a;
        c   = 1'b0;
        v   = 1'b0;
        unique case (fn)
            FN_PASS_A: y = a;
            FN_PASS_B: y = b;
            FN_OR:     y = a | b;
            FN_AND:    y = a & b;
            FN_EOR:    y = a ^ b;
            FN_ADD, FN_SUB: begin
                y = sum[7:0];
                c = sum[8];
                v = (a[7] == bx[7]) && (sum[7] != a[7]);
            end
            FN_BIT: begin
                y = a & b;
                v = b[6];
            end
            FN_ASL: begin
                y = {a[6:0], 1'b0};
                c = a[7];
            end
            FN_LSR: begin
                y = {1'b0, a[7:1]};
                c = a[0];
            end
            FN_ROL: begin
                y = {a[6:0], cin};
                c = a[7];
            end
            FN_ROR: begin
                y = {cin, a[7:1]};
                c = a[0];
            end
            FN_INC:    y = a + 8'd1;
            FN_DEC:    y = a - 8'd1;
            default:   y = a;
        endcase
        flags[FLAG_N] = (fn == FN_BIT) ? b[7] : y[7];
        flags[FLAG_V] = v;
        flags[FLAG_Z] = (y == 8'd0);
        flags[FLAG_C] = c;
    end

endmodule

// File: rtl/core_alu_seq.sv
// ALU operation sequencer and {N,V,Z,C} flag register owner.
// Define CORE_ALU_SEQ_ADD16_EN to build the two-pass 16-bit address add.
module core_alu_seq
    import core_alu_seq_pkg::*;
(
    input  logic          I_clock,
    input  logic          I_reset_n,
    core_alu_seq_if.slave bus
);

    state_type    state_q, state_d;
    op_type       op_q;
    logic [7:0]   lhs_q, rhs_q;
    logic [3:0]   flags_q;
    logic         resp_q;
    logic [7:0]   result_q;
    logic         ready, accept;
    logic         exec_single;
    alu_ctrl_type ctrl;
    alu_fn_type   alu_fn;
    logic [7:0]   alu_a, alu_b, alu_y;
    logic         alu_cin;
    logic [3:0]   alu_flags;
`ifdef CORE_ALU_SEQ_ADD16_EN
    logic [7:0]   lhs_hi_q, lo_q, result_hi_q;
    logic         pc_q, page_cross_q;
    logic         exec_lo;
`else
    logic         unused_lhs_hi;
    assign unused_lhs_hi = ^bus.I_req_lhs[15:8];
`endif

    assign ctrl   = op_ctrl(op_q);
    assign accept = bus.I_req_valid & ready;
`ifdef CORE_ALU_SEQ_ADD16_EN
    assign exec_lo     = (state_q == ST_EXEC) && (op_q == OP_ADD16);
    assign exec_single = (state_q == ST_EXEC) && (op_q != OP_ADD16);
`else
    assign exec_single = (state_q == ST_EXEC);
`endif

    // Next state and request-ready decode
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.I_req_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
`ifdef CORE_ALU_SEQ_ADD16_EN
                ready = exec_single;
                if (exec_lo)                 state_d = ST_EXEC_HI;
                else if (bus.I_req_valid)    state_d = ST_EXEC;
                else                         state_d = ST_IDLE;
`else
                ready = 1'b1;
                state_d = bus.I_req_valid ? ST_EXEC : ST_IDLE;
`endif
            end
`ifdef CORE_ALU_SEQ_ADD16_EN
            ST_EXEC_HI: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU operand/carry select; the high pass adds only the latched carry
    always_comb begin
        alu_fn = ctrl.fn;
        alu_a  = lhs_q;
        alu_b  = rhs_q;
        unique case (ctrl.cin)
            CIN_FLAG: alu_cin = flags_q[FLAG_C];
            CIN_ONE:  alu_cin = 1'b1;
            default:  alu_cin = 1'b0;
        endcase
`ifdef CORE_ALU_SEQ_ADD16_EN
        if (state_q == ST_EXEC_HI) begin
            alu_fn  = FN_ADD;
            alu_a   = lhs_hi_q;
            alu_b   = 8'h00;
            alu_cin = pc_q;
        end
`endif
    end

    core_alu u_alu (
        .fn    (alu_fn),
        .a     (alu_a),
        .b     (alu_b),
        .cin   (alu_cin),
        .y     (alu_y),
        .flags (alu_flags)
    );

    // State register
    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Operand capture on accept
    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            op_q  <= OP_NOP;
            lhs_q <= 8'h00;
            rhs_q <= 8'h00;
`ifdef CORE_ALU_SEQ_ADD16_EN
            lhs_hi_q <= 8'h00;
`endif
        end else if (accept) begin
            op_q  <= op_type'(bus.I_req_op);
            lhs_q <= bus.I_req_lhs[7:0];
            rhs_q <= bus.I_req_rhs;
`ifdef CORE_ALU_SEQ_ADD16_EN
            lhs_hi_q <= bus.I_req_lhs[15:8];
`endif
        end
    end

    // Flag register: an external write overrides the op's update
    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n)
            flags_q <= 4'b0000;
        else if (bus.I_flags_wr)
            flags_q <= bus.I_flags;
        else if (exec_single)
            flags_q <= (flags_q & ~ctrl.upd) | (alu_flags & ctrl.upd);
    end

    // Response registers; results hold until the next response
    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            resp_q   <= 1'b0;
            result_q <= 8'h00;
`ifdef CORE_ALU_SEQ_ADD16_EN
            result_hi_q  <= 8'h00;
            page_cross_q <= 1'b0;
            lo_q         <= 8'h00;
            pc_q         <= 1'b0;
`endif
        end else begin
            resp_q <= 1'b0;
            if (exec_single) begin
                resp_q   <= 1'b1;
                result_q <= alu_y;
`ifdef CORE_ALU_SEQ_ADD16_EN
                result_hi_q  <= 8'h00;
                page_cross_q <= 1'b0;
`endif
            end
`ifdef CORE_ALU_SEQ_ADD16_EN
            if (exec_lo) begin
                lo_q <= alu_y;
                pc_q <= alu_flags[FLAG_C];
            end
            if (state_q == ST_EXEC_HI) begin
                resp_q       <= 1'b1;
                result_q     <= lo_q;
                result_hi_q  <= alu_y;
                page_cross_q <= pc_q;
            end
`endif
        end
    end

    assign bus.O_req_ready  = ready;
    assign bus.O_resp_valid = resp_q;
    assign bus.O_result     = result_q;
    assign bus.O_flags      = flags_q;
`ifdef CORE_ALU_SEQ_ADD16_EN
    assign bus.O_result_hi  = result_hi_q;
    assign bus.O_page_cross = page_cross_q;
`else
    assign bus.O_result_hi  = 8'h00;
    assign bus.O_page_cross = 1'b0;
`endif

endmodule

// File: tb/tb_core_alu_seq.sv
// Testbench for core_alu_seq: event-level reference model plus
// directed vectors with hand-computed expectations.
module tb_core_alu_seq;

`ifdef CORE_ALU_SEQ_ADD16_EN
    localparam bit ADD16_EN = 1'b1;
`else
    localparam bit ADD16_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    core_alu_seq_if bus ();

    core_alu_seq dut (
        .I_clock   (clk),
        .I_reset_n (rst_n),
        .bus       (bus)
    );

    // Expected-output state produced by the reference model
    logic [3:0]  m_flags;
    logic        m_exec, m_hi, m_pc;
    logic [3:0]  m_op;
    logic [15:0] m_lhs;
    logic [7:0]  m_rhs, m_lo;
    logic        e_ready, e_valid, e_pc;
    logic [7:0]  e_res, e_hi;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Architectural effect of one single-pass op on result and flags
    function automatic void ref_op(input logic [3:0] op,
                                   input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic [3:0] f,
                                   output logic [7:0] r,
                                   output logic [3:0] nf);
        int c, s, sv;
        bit nz;
        c  = int'(f[0]);
        nf = f;
        r  = a;
        nz = 1'b1;
        case (op)
            4'h0: r = b;
            4'h1: r = a | b;
            4'h2: r = a & b;
            4'h3: r = a ^ b;
            4'h4: begin
                s  = int'(a) + int'(b) + c;
                sv = int'($signed(a)) + int'($signed(b)) + c;
                r  = 8'(s);
                nf[0] = (s > 255);
                nf[2] = (sv > 127) || (sv < -128);
            end
            4'h5: begin
                s  = int'(a) - int'(b) - (1 - c);
                sv = int'($signed(a)) - int'($signed(b)) - (1 - c);
                r  = 8'(s);
                nf[0] = (s >= 0);
                nf[2] = (sv > 127) || (sv < -128);
            end
            4'h6: begin
                s  = int'(a) - int'(b);
                r  = 8'(s);
                nf[0] = (s >= 0);
            end
            4'h7: begin
                r  = a & b;
                nz = 1'b0;
                nf[3] = b[7];
                nf[2] = b[6];
                nf[1] = (r == 8'd0);
            end
            4'h8: begin r = {a[6:0], 1'b0}; nf[0] = a[7]; end
            4'h9: begin r = {1'b0, a[7:1]}; nf[0] = a[0]; end
            4'hA: begin r = {a[6:0], f[0]}; nf[0] = a[7]; end
            4'hB: begin r = {f[0], a[7:1]}; nf[0] = a[0]; end
            4'hC: r = a + 8'd1;
            4'hD: r = a - 8'd1;
            default: begin r = a; nz = 1'b0; end
        endcase
        if (nz) begin
            nf[3] = r[7];
            nf[1] = (r == 8'd0);
        end
    endfunction

    // Reference model: advances once per clock edge or on reset
    initial begin : model
        logic       acc;
        logic [7:0] r;
        logic [3:0] nf;
        logic [8:0] s;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_flags = 4'b0; m_exec = 1'b0; m_hi = 1'b0; m_pc = 1'b0;
                m_op = 4'h0; m_lhs = 16'h0; m_rhs = 8'h0; m_lo = 8'h0;
                e_ready = 1'b1; e_valid = 1'b0; e_pc = 1'b0;
                e_res = 8'h0; e_hi = 8'h0;
            end else begin
                acc = bus.I_req_valid && e_ready;
                e_valid = 1'b0;
                if (m_hi) begin
                    e_valid = 1'b1;
                    e_res = m_lo;
                    e_hi = m_lhs[15:8] + {7'd0, m_pc};
                    e_pc = m_pc;
                    m_hi = 1'b0;
                end else if (m_exec) begin
                    if (ADD16_EN && m_op == 4'hE) begin
                        s = {1'b0, m_lhs[7:0]} + {1'b0, m_rhs};
                        m_lo = s[7:0];
                        m_pc = s[8];
                        m_hi = 1'b1;
                    end else begin
                        ref_op(m_op, m_lhs[7:0], m_rhs, m_flags, r, nf);
                        e_valid = 1'b1;
                        e_res = r;
                        e_hi = 8'h00;
                        e_pc = 1'b0;
                        m_flags = nf;
                    end
                end
                if (bus.I_flags_wr) m_flags = bus.I_flags;
                m_exec = acc;
                if (acc) begin
                    m_op = bus.I_req_op;
                    m_lhs = bus.I_req_lhs;
                    m_rhs = bus.I_req_rhs;
                end
                e_ready = !m_hi && !(m_exec && ADD16_EN && m_op == 4'hE);
            end
        end
    end

    // Cycle-by-cycle comparison of DUT against the model
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("sb_ready", 16'(bus.O_req_ready), 16'(e_ready));
                check("sb_valid", 16'(bus.O_resp_valid), 16'(e_valid));
                check("sb_flags", 16'(bus.O_flags), 16'(m_flags));
                check("sb_result", 16'(bus.O_result), 16'(e_res));
                check("sb_result_hi", 16'(bus.O_result_hi), 16'(e_hi));
                check("sb_page_cross", 16'(bus.O_page_cross), 16'(e_pc));
            end
        end
    end

    // Drive a request at a falling edge and hold until accepted
    task automatic send(input logic [3:0] op, input logic [15:0] lhs,
                        input logic [7:0] rhs);
        int n;
        bus.I_req_valid = 1'b1;
        bus.I_req_op = op;
        bus.I_req_lhs = lhs;
        bus.I_req_rhs = rhs;
        n = 0;
        while (!bus.O_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.O_req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ready got 0 want 1 at %0t", $time);
        end
        @(posedge clk);
        @(negedge clk);
        bus.I_req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.O_resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.O_resp_valid) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: valid got 0 want 1 at %0t", $time);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        bus.I_flags_wr = 1'b1;
        bus.I_flags = f;
        @(negedge clk);
        bus.I_flags_wr = 1'b0;
    endtask

    logic [7:0] va [6] = '{8'h00, 8'h7F, 8'h80, 8'hA5, 8'hFF, 8'h3C};
    logic [7:0] vb [6] = '{8'h00, 8'h01, 8'hFF, 8'h5A, 8'h01, 8'hC3};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin : main
        int lat;
        rst_n = 1'b0;
        bus.I_req_valid = 1'b0;
        bus.I_req_op = 4'h0;
        bus.I_req_lhs = 16'h0;
        bus.I_req_rhs = 8'h0;
        bus.I_flags_wr = 1'b0;
        bus.I_flags = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        check("rst_ready", 16'(bus.O_req_ready), 16'h1);
        check("rst_valid", 16'(bus.O_resp_valid), 16'h0);
        check("rst_result", 16'(bus.O_result), 16'h0);
        check("rst_hi", 16'(bus.O_result_hi), 16'h0);
        check("rst_pc", 16'(bus.O_page_cross), 16'h0);
        check("rst_flags", 16'(bus.O_flags), 16'h0);

        send(4'h4, 16'h0050, 8'h50);
        wait_resp(lat);
        check("adc_lat", 16'(lat), 16'd2);
        check("adc_res", 16'(bus.O_result), 16'h00A0);
        check("adc_flags", 16'(bus.O_flags), 16'b1100);

        set_flags(4'b0001);
        send(4'h5, 16'h0000, 8'h01);
        send(4'h5, 16'h0010, 8'h01);
        check("sbc1_res", 16'(bus.O_result), 16'h00FF);
        check("sbc1_flags", 16'(bus.O_flags), 16'b1000);
        @(negedge clk);
        check("sbc2_res", 16'(bus.O_result), 16'h000E);
        check("sbc2_flags", 16'(bus.O_flags), 16'b0001);

        set_flags(4'b0100);
        send(4'h6, 16'h0040, 8'h40);
        wait_resp(lat);
        check("cmp_res", 16'(bus.O_result), 16'h0000);
        check("cmp_flags", 16'(bus.O_flags), 16'b0111);

        set_flags(4'b0001);
        send(4'h7, 16'h0001, 8'hC0);
        wait_resp(lat);
        check("bit_res", 16'(bus.O_result), 16'h0000);
        check("bit_flags", 16'(bus.O_flags), 16'b1111);

        set_flags(4'b0001);
        send(4'hA, 16'h0080, 8'h00);
        send(4'hA, 16'h0000, 8'h00);
        check("rol1_res", 16'(bus.O_result), 16'h0001);
        check("rol1_flags", 16'(bus.O_flags), 16'b0001);
        @(negedge clk);
        check("rol2_res", 16'(bus.O_result), 16'h0001);
        check("rol2_flags", 16'(bus.O_flags), 16'b0000);

        set_flags(4'b0000);
        send(4'h4, 16'h0050, 8'h50);
        bus.I_flags_wr = 1'b1;
        bus.I_flags = 4'b0001;
        @(negedge clk);
        bus.I_flags_wr = 1'b0;
        check("fwr_res", 16'(bus.O_result), 16'h00A0);
        check("fwr_flags", 16'(bus.O_flags), 16'b0001);

`ifdef CORE_ALU_SEQ_ADD16_EN
        send(4'hE, 16'h12F0, 8'h20);
        check("a16_rdy_exec", 16'(bus.O_req_ready), 16'h0);
        @(negedge clk);
        check("a16_rdy_hi", 16'(bus.O_req_ready), 16'h0);
        check("a16_no_early", 16'(bus.O_resp_valid), 16'h0);
        @(negedge clk);
        check("a16_valid", 16'(bus.O_resp_valid), 16'h1);
        check("a16_lo", 16'(bus.O_result), 16'h0010);
        check("a16_hi", 16'(bus.O_result_hi), 16'h0013);
        check("a16_pc", 16'(bus.O_page_cross), 16'h1);
        check("a16_flags", 16'(bus.O_flags), 16'b0001);
        send(4'hE, 16'hFFFF, 8'h01);
        wait_resp(lat);
        check("a16w_lat", 16'(lat), 16'd3);
        check("a16w_lo", 16'(bus.O_result), 16'h0000);
        check("a16w_hi", 16'(bus.O_result_hi), 16'h0000);
        check("a16w_pc", 16'(bus.O_page_cross), 16'h1);
`else
        send(4'hE, 16'h12F0, 8'h20);
        wait_resp(lat);
        check("nop_lat", 16'(lat), 16'd2);
        check("nop_res", 16'(bus.O_result), 16'h00F0);
        check("nop_hi", 16'(bus.O_result_hi), 16'h0000);
        check("nop_pc", 16'(bus.O_page_cross), 16'h0);
        check("nop_flags", 16'(bus.O_flags), 16'b0001);
`endif

        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 6; k++) begin
                send(4'(op), {vb[k], va[k]}, vb[k]);
            end
        end
        repeat (4) @(negedge clk);

        set_flags(4'b1011);
`ifdef CORE_ALU_SEQ_ADD16_EN
        send(4'hE, 16'hABCD, 8'h40);
        chk_en = 1'b0;
        @(negedge clk);
`else
        send(4'h4, 16'h0011, 8'h22);
        chk_en = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        check("arst_valid", 16'(bus.O_resp_valid), 16'h0);
        check("arst_flags", 16'(bus.O_flags), 16'h0);
        check("arst_ready", 16'(bus.O_req_ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", 16'(bus.O_resp_valid), 16'h0);
            check("post_rst_flags", 16'(bus.O_flags), 16'h0);
            check("post_rst_ready", 16'(bus.O_req_ready), 16'h1);
        end
        chk_en = 1'b1;
        send(4'h0, 16'h0000, 8'h80);
        wait_resp(lat);
        check("ld_res", 16'(bus.O_result), 16'h0080);
        check("ld_flags", 16'(bus.O_flags), 16'b1000);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
